data_memory: RTL

Data-side memory responder for the single-cycle 32-bit processor. It answers the datapath's load/store requests: combinational read data within the same cycle, write commit on the clock edge. It holds word-addressed RAM plus a small memory-mapped I/O (MMIO) window with three registers: an output port, a free-running cycle counter and a sticky error/status register.

---
 rtl/data_memory.sv | 114 +++++++++++
 1 files changed

// File: rtl/data_memory.sv
// data_memory: word-addressed data RAM plus a small MMIO window (output port,
// free-running cycle counter, sticky misalign status) for a single-cycle core.
// Loads are answered combinationally; stores commit on the rising clock edge.
module data_memory #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemAddress,
  input  logic [31:0] MemWriteData,
  output logic [31:0] MemReadData,
  output logic [31:0] OutPort,
  output logic        MisalignErr
);

  localparam logic [3:0]  MMIO_TAG = 4'hF;
  localparam logic [27:0] OFF_OUT  = 28'h000_0000;
  localparam logic [27:0] OFF_CNT  = 28'h000_0004;
  localparam logic [27:0] OFF_STAT = 28'h000_0008;

  logic [31:0] ram_q [DEPTH];
  logic [31:0] ram_d [DEPTH];
  logic [31:0] out_q, out_d;
  logic [31:0] cnt_q, cnt_d;
  logic        stat_q, stat_d;

  logic          is_mmio_c;
  logic          misalign_c;
  logic          wr_ok_c;
  logic [27:0]   offset_c;
  logic [AW-1:0] ram_idx_c;
  logic          sel_out_c;
  logic          sel_cnt_c;
  logic          sel_stat_c;
  logic [31:0]   rd_data_c;

  // Address decode and access qualification
  always_comb begin
    is_mmio_c  = (MemAddress[31:28] == MMIO_TAG);
    offset_c   = MemAddress[27:0];
    ram_idx_c  = MemAddress[AW+1:2];
    misalign_c = (MemAddress[1:0] != 2'b00) && (MemRead || MemWrite);
    wr_ok_c    = MemWrite && !misalign_c;
    sel_out_c  = is_mmio_c && (offset_c == OFF_OUT);
    sel_cnt_c  = is_mmio_c && (offset_c == OFF_CNT);
    sel_stat_c = is_mmio_c && (offset_c == OFF_STAT);
  end

  // Next-state for RAM and MMIO registers; a new misalign beats a status clear
  always_comb begin
    ram_d  = ram_q;
    out_d  = out_q;
    cnt_d  = cnt_q + 32'd1;
    stat_d = stat_q;
    if (wr_ok_c && !is_mmio_c) begin
      ram_d[ram_idx_c] = MemWriteData;
    end
    if (wr_ok_c && sel_out_c) begin
      out_d = MemWriteData;
    end
    if (wr_ok_c && sel_cnt_c) begin
      cnt_d = MemWriteData;
    end
    if (wr_ok_c && sel_stat_c && MemWriteData[0]) begin
      stat_d = 1'b0;
    end
    if (misalign_c) begin
      stat_d = 1'b1;
    end
  end

  // State registers with synchronous reset clearing RAM and all MMIO state
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ram_q[i] <= '0;
      end
      out_q  <= '0;
      cnt_q  <= '0;
      stat_q <= 1'b0;
    end else begin
      ram_q  <= ram_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      stat_q <= stat_d;
    end
  end

  // Zero-latency read mux; pre-write value is returned on a same-cycle store
  always_comb begin
    rd_data_c = '0;
    if (MemRead && !misalign_c) begin
      if (is_mmio_c) begin
        if (sel_out_c) begin
          rd_data_c = out_q;
        end else if (sel_cnt_c) begin
          rd_data_c = cnt_q;
        end else if (sel_stat_c) begin
          rd_data_c = {31'd0, stat_q};
        end
      end else begin
        rd_data_c = ram_q[ram_idx_c];
      end
    end
  end

  assign MemReadData = rd_data_c;
  assign OutPort     = out_q;
  assign MisalignErr = stat_q;

endmodule
